biu_ram_responder: RTL and testbench

- BIU target (responder) that terminates one BIU initiator port, e.g. the output of the BIU mux, on a local word-organised RAM.
- Accepts single and burst requests.
- Generates incrementing and wrapping beat addresses and byte-lane write enables.
- Returns per-beat ack/err, read data and the response address; supports programmable wait states.

---
 rtl/biu_ram_responder_pkg.sv | 23 ++
 rtl/biu_ram_responder.sv | 194 +++++++++++++++++++
 tb/tb_biu_ram_responder.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/biu_ram_responder_pkg.sv
// BIU transfer encodings used by biu_ram_responder and its initiators.
// The size code n means a transfer of 2^n bytes.
package biu_ram_responder_pkg;
    typedef enum logic [1:0] {
        BYTE  = 2'd0,
        HWORD = 2'd1,
        WORD  = 2'd2,
        DWORD = 2'd3
    } biu_size_t;

    typedef enum logic [2:0] {
        SINGLE = 3'd0,
        INCR   = 3'd1,
        WRAP4  = 3'd2,
        INCR4  = 3'd3,
        WRAP8  = 3'd4,
        INCR8  = 3'd5,
        WRAP16 = 3'd6,
        INCR16 = 3'd7
    } biu_type_t;

    typedef logic [2:0] biu_prot_t;
endpackage

// File: rtl/biu_ram_responder.sv
// BIU responder terminating one initiator port on a local word-wide RAM.
// Handles single/burst (incrementing and wrapping) accesses with optional wait states.
module biu_ram_responder
    import biu_ram_responder_pkg::*;
#(
    parameter int                    ADDR_SIZE   = 32,
    parameter int                    DATA_SIZE   = 32,
    parameter int                    DEPTH       = 1024,
    parameter logic [ADDR_SIZE-1:0]  BASE_ADDR   = '0,
    parameter int                    WAIT_STATES = 0
) (
    input  logic                 rst_ni,
    input  logic                 clk_i,
    input  logic                 biu_req_i,
    output logic                 biu_req_ack_o,
    output logic                 biu_d_ack_o,
    input  logic [ADDR_SIZE-1:0] biu_adri_i,
    output logic [ADDR_SIZE-1:0] biu_adro_o,
    input  biu_size_t            biu_size_i,
    input  biu_type_t            biu_type_i,
    input  logic                 biu_lock_i,
    input  biu_prot_t            biu_prot_i,
    input  logic                 biu_we_i,
    input  logic [DATA_SIZE-1:0] biu_d_i,
    output logic [DATA_SIZE-1:0] biu_q_o,
    output logic                 biu_ack_o,
    output logic                 biu_err_o
);
    localparam int BYTES = DATA_SIZE / 8;
    localparam int LB    = $clog2(BYTES);
    localparam int IW    = $clog2(DEPTH);
    localparam logic [ADDR_SIZE:0] LIMIT = {1'b0, BASE_ADDR} + (ADDR_SIZE+1)'(DEPTH * BYTES);

    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BEAT} state_t;

    state_t                r_state;
    logic [ADDR_SIZE-1:0]  r_addr;
    biu_size_t             r_size;
    biu_type_t             r_type;
    logic                  r_we;
    logic [4:0]            r_left;
    logic [3:0]            r_wcnt;
    logic                  r_ack, r_err, r_d_ack, r_q_zero;
    logic [ADDR_SIZE-1:0]  r_adro;
    logic [IW-1:0]         r_idx;
    logic [BYTES-1:0]      r_be, r_fwd_be;
    logic [DATA_SIZE-1:0]  r_fwd_d, r_ram_q;
    logic [DATA_SIZE-1:0]  r_mem [DEPTH];

    logic                  w_last, w_is_wrap, w_bt_valid, w_bt_we, w_bt_err, w_wr_en, w_rd_load;
    logic [ADDR_SIZE-1:0]  w_step, w_wrap_mask, w_incr, w_next_addr, w_bt_addr, w_off, w_size_mask;
    biu_size_t             w_bt_size;
    logic [IW-1:0]         w_bt_idx;
    logic [BYTES-1:0]      w_bt_be;
    logic [DATA_SIZE-1:0]  w_q;
    int                    w_lane, w_nbytes;
    logic                  w_unused;

    function automatic logic [4:0] f_beats(input biu_type_t t);
        case (t)
            WRAP4, INCR4:   f_beats = 5'd4;
            WRAP8, INCR8:   f_beats = 5'd8;
            WRAP16, INCR16: f_beats = 5'd16;
            default:        f_beats = 5'd1;
        endcase
    endfunction

    assign w_last        = (r_state == ST_BEAT) && (r_left == 5'd1);
    assign biu_req_ack_o = biu_req_i & ((r_state == ST_IDLE) | w_last) & rst_ni;

    // Wrapping keeps the upper bits and wraps inside the N*2^size aligned block.
    assign w_step      = ADDR_SIZE'(1) << r_size;
    assign w_wrap_mask = (ADDR_SIZE'(f_beats(r_type)) << r_size) - ADDR_SIZE'(1);
    assign w_incr      = r_addr + w_step;
    assign w_is_wrap   = r_type inside {WRAP4, WRAP8, WRAP16};
    assign w_next_addr = w_is_wrap ? ((r_addr & ~w_wrap_mask) | (w_incr & w_wrap_mask)) : w_incr;

    // Beat being set up this cycle; its outputs appear registered in the next cycle.
    always_comb begin
        w_bt_valid = 1'b0;
        w_bt_addr  = r_addr;
        w_bt_size  = r_size;
        w_bt_we    = r_we;
        if (biu_req_ack_o && WAIT_STATES == 0) begin
            w_bt_valid = 1'b1;
            w_bt_addr  = biu_adri_i;
            w_bt_size  = biu_size_i;
            w_bt_we    = biu_we_i;
        end else if (r_state == ST_BEAT && !w_last && WAIT_STATES == 0) begin
            w_bt_valid = 1'b1;
            w_bt_addr  = w_next_addr;
        end else if (r_state == ST_WAIT && r_wcnt == 4'd0) begin
            w_bt_valid = 1'b1;
        end
    end

    assign w_size_mask = (ADDR_SIZE'(1) << w_bt_size) - ADDR_SIZE'(1);
    assign w_bt_err    = (|(w_bt_addr & w_size_mask))
                       | (int'(w_bt_size) > LB)
                       | ({1'b0, w_bt_addr} < {1'b0, BASE_ADDR})
                       | ({1'b0, w_bt_addr} >= LIMIT);
    assign w_off       = w_bt_addr - BASE_ADDR;
    assign w_bt_idx    = w_off[LB +: IW];
    assign w_lane      = int'(w_bt_addr[LB-1:0]);
    assign w_nbytes    = 1 << int'(w_bt_size);
    assign w_wr_en     = r_d_ack & r_ack;
    assign w_rd_load   = w_bt_valid & ~w_bt_we & ~w_bt_err;

    // A read set up in the same cycle as a write to its word takes the new bytes.
    for (genvar gi = 0; gi < BYTES; gi++) begin : g_lane
        assign w_bt_be[gi]       = (gi >= w_lane) && (gi < w_lane + w_nbytes);
        assign w_q[gi*8 +: 8]    = r_fwd_be[gi] ? r_fwd_d[gi*8 +: 8] : r_ram_q[gi*8 +: 8];
    end

    always_ff @(posedge clk_i) begin
        if (w_wr_en) begin
            for (int b = 0; b < BYTES; b++) begin
                if (r_be[b]) r_mem[r_idx][b*8 +: 8] <= biu_d_i[b*8 +: 8];
            end
        end
        if (w_rd_load) r_ram_q <= r_mem[w_bt_idx];
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state  <= ST_IDLE;
            r_addr   <= '0;
            r_size   <= BYTE;
            r_type   <= SINGLE;
            r_we     <= 1'b0;
            r_left   <= '0;
            r_wcnt   <= '0;
            r_ack    <= 1'b0;
            r_err    <= 1'b0;
            r_d_ack  <= 1'b0;
            r_q_zero <= 1'b1;
            r_adro   <= '0;
            r_idx    <= '0;
            r_be     <= '0;
            r_fwd_be <= '0;
            r_fwd_d  <= '0;
        end else begin
            r_ack   <= w_bt_valid & ~w_bt_err;
            r_err   <= w_bt_valid & w_bt_err;
            r_d_ack <= w_bt_valid & w_bt_we;
            if (w_bt_valid) begin
                r_adro <= w_bt_addr;
                r_idx  <= w_bt_idx;
                r_be   <= w_bt_be;
            end
            if (w_bt_valid && !w_bt_we) r_q_zero <= w_bt_err;
            if (w_rd_load) begin
                for (int b = 0; b < BYTES; b++) begin
                    r_fwd_be[b] <= w_wr_en & r_be[b] & (r_idx == w_bt_idx);
                end
                r_fwd_d <= biu_d_i;
            end
            if (biu_req_ack_o) begin
                r_addr  <= biu_adri_i;
                r_size  <= biu_size_i;
                r_type  <= biu_type_i;
                r_we    <= biu_we_i;
                r_left  <= f_beats(biu_type_i);
                r_wcnt  <= 4'(WAIT_STATES - 1);
                r_state <= (WAIT_STATES == 0) ? ST_BEAT : ST_WAIT;
            end else begin
                case (r_state)
                    ST_WAIT: begin
                        if (r_wcnt == 4'd0) r_state <= ST_BEAT;
                        else                r_wcnt  <= r_wcnt - 4'd1;
                    end
                    ST_BEAT: begin
                        if (!w_last) begin
                            r_left  <= r_left - 5'd1;
                            r_addr  <= w_next_addr;
                            r_wcnt  <= 4'(WAIT_STATES - 1);
                            r_state <= (WAIT_STATES == 0) ? ST_BEAT : ST_WAIT;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign biu_ack_o   = r_ack;
    assign biu_err_o   = r_err;
    assign biu_d_ack_o = r_d_ack;
    assign biu_adro_o  = r_adro;
    assign biu_q_o     = r_q_zero ? '0 : w_q;
    assign w_unused    = ^{biu_lock_i, biu_prot_i, w_off};
endmodule

// File: tb/tb_biu_ram_responder.sv
// Directed bench for biu_ram_responder: one instance without wait states,
// one with two wait states for the reset-during-burst scenario.
module tb_biu_ram_responder;
    import biu_ram_responder_pkg::*;

    logic        clk;
    int          n_chk = 0;
    int          n_err = 0;

    // Instance A (no wait states)
    logic        rst_n, req, we, req_ack, d_ack, ack, err;
    logic [31:0] adri, adro, d, q;
    biu_size_t   size;
    biu_type_t   typ;

    // Instance B (two wait states)
    logic        b_rst_n, b_req, b_we, b_req_ack, b_d_ack, b_ack, b_err;
    logic [31:0] b_adri, b_adro, b_d, b_q;
    biu_size_t   b_size;
    biu_type_t   b_typ;

    biu_ram_responder #(.WAIT_STATES(0)) u_dut (
        .rst_ni(rst_n), .clk_i(clk), .biu_req_i(req), .biu_req_ack_o(req_ack),
        .biu_d_ack_o(d_ack), .biu_adri_i(adri), .biu_adro_o(adro), .biu_size_i(size),
        .biu_type_i(typ), .biu_lock_i(1'b0), .biu_prot_i(3'b000), .biu_we_i(we),
        .biu_d_i(d), .biu_q_o(q), .biu_ack_o(ack), .biu_err_o(err)
    );

    biu_ram_responder #(.WAIT_STATES(2)) u_dut_w (
        .rst_ni(b_rst_n), .clk_i(clk), .biu_req_i(b_req), .biu_req_ack_o(b_req_ack),
        .biu_d_ack_o(b_d_ack), .biu_adri_i(b_adri), .biu_adro_o(b_adro), .biu_size_i(b_size),
        .biu_type_i(b_typ), .biu_lock_i(1'b0), .biu_prot_i(3'b000), .biu_we_i(b_we),
        .biu_d_i(b_d), .biu_q_o(b_q), .biu_ack_o(b_ack), .biu_err_o(b_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic a_issue(input logic [31:0] a, input biu_size_t s, input biu_type_t t,
                           input logic w, input logic [31:0] dd);
        req = 1'b1; adri = a; size = s; typ = t; we = w; d = dd;
    endtask

    // One SINGLE transfer on instance A: accept cycle, then the beat cycle.
    task automatic a_single(input string tag, input logic [31:0] a, input biu_size_t s,
                            input logic w, input logic [31:0] dd, input logic exp_err,
                            input logic chk_q, input logic [31:0] exp_q);
        a_issue(a, s, SINGLE, w, dd);
        @(negedge clk);
        chk({tag, "_req_ack"}, 64'(req_ack), 64'(1));
        nxt();
        req = 1'b0;
        @(negedge clk);
        chk({tag, "_ack"}, 64'(ack), 64'(!exp_err));
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        chk({tag, "_adro"}, 64'(adro), 64'(a));
        if (!exp_err) chk({tag, "_d_ack"}, 64'(d_ack), 64'(w));
        if (chk_q)    chk({tag, "_q"}, 64'(q), 64'(exp_q));
        $display("xfer %s: addr=0x%0h we=%0b ack=%0b err=%0b q=0x%0h", tag, a, w, ack, err, q);
        nxt();
    endtask

    initial begin
        logic [31:0] exp_wrap [4];
        logic [31:0] exp_b2b  [5];
        int          cnt;

        exp_wrap = '{32'h18, 32'h1C, 32'h10, 32'h14};
        exp_b2b  = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h80};

        rst_n = 1'b0; req = 1'b0; we = 1'b0; adri = '0; d = '0; size = WORD; typ = SINGLE;
        b_rst_n = 1'b0; b_req = 1'b0; b_we = 1'b0; b_adri = '0; b_d = '0; b_size = WORD; b_typ = SINGLE;
        nxt(); nxt();
        @(negedge clk);
        chk("rst_req_ack", 64'(req_ack), 64'(0));
        chk("rst_ack",     64'(ack),     64'(0));
        chk("rst_err",     64'(err),     64'(0));
        chk("rst_d_ack",   64'(d_ack),   64'(0));
        chk("rst_q",       64'(q),       64'(0));
        chk("rst_adro",    64'(adro),    64'(0));
        $display("xfer reset: outputs sampled");
        nxt();
        rst_n = 1'b1; b_rst_n = 1'b1;
        nxt();

        // Single write then read back
        a_single("wr10", 32'h10, WORD, 1'b1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
        a_single("rd10", 32'h10, WORD, 1'b0, 32'h0, 1'b0, 1'b1, 32'hDEADBEEF);

        // WRAP4 read starting mid-block
        a_issue(32'h18, WORD, WRAP4, 1'b0, 32'h0);
        @(negedge clk);
        chk("wrap4_req_ack", 64'(req_ack), 64'(1));
        nxt();
        req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("wrap4_ack%0d", i),  64'(ack),  64'(1));
            chk($sformatf("wrap4_err%0d", i),  64'(err),  64'(0));
            chk($sformatf("wrap4_adro%0d", i), 64'(adro), 64'(exp_wrap[i]));
            $display("xfer wrap4 beat %0d: adro=0x%0h", i, adro);
            nxt();
        end
        @(negedge clk);
        chk("wrap4_end_ack", 64'(ack), 64'(0));
        nxt();

        // Byte-lane write
        a_single("wr20",  32'h20, WORD, 1'b1, 32'h11223344, 1'b0, 1'b0, 32'h0);
        a_single("wrb21", 32'h21, BYTE, 1'b1, 32'h0000AA00, 1'b0, 1'b0, 32'h0);
        a_single("rd20",  32'h20, WORD, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1122AA44);

        // Error cases
        a_single("wr00",   32'h0,    WORD,  1'b1, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
        a_single("rdmis",  32'h2,    WORD,  1'b0, 32'h0,        1'b1, 1'b1, 32'h0);
        a_single("wroor",  32'h1000, WORD,  1'b1, 32'h55555555, 1'b1, 1'b0, 32'h0);
        a_single("rd00",   32'h0,    WORD,  1'b0, 32'h0,        1'b0, 1'b1, 32'hCAFEF00D);
        a_single("rddw",   32'h8,    DWORD, 1'b0, 32'h0,        1'b1, 1'b1, 32'h0);

        // INCR4 followed back-to-back by a SINGLE
        a_issue(32'h40, WORD, INCR4, 1'b0, 32'h0);
        @(negedge clk);
        chk("b2b_req_ack_first", 64'(req_ack), 64'(1));
        nxt();
        a_issue(32'h80, WORD, SINGLE, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("b2b_ack%0d", i),     64'(ack),     64'(1));
            chk($sformatf("b2b_adro%0d", i),    64'(adro),    64'(exp_b2b[i]));
            chk($sformatf("b2b_req_ack%0d", i), 64'(req_ack), 64'(i == 3));
            $display("xfer b2b beat %0d: adro=0x%0h req_ack=%0b", i, adro, req_ack);
            nxt();
            if (i == 3) req = 1'b0;
        end
        @(negedge clk);
        chk("b2b_end_ack", 64'(ack), 64'(0));
        nxt();

        // Write immediately followed by a read of the same word
        a_issue(32'h60, WORD, SINGLE, 1'b1, 32'h0BADCAFE);
        @(negedge clk);
        chk("fwd_wr_req_ack", 64'(req_ack), 64'(1));
        nxt();
        a_issue(32'h60, WORD, SINGLE, 1'b0, 32'h0BADCAFE);
        @(negedge clk);
        chk("fwd_wr_d_ack",   64'(d_ack),   64'(1));
        chk("fwd_rd_req_ack", 64'(req_ack), 64'(1));
        nxt();
        req = 1'b0;
        @(negedge clk);
        chk("fwd_rd_ack", 64'(ack), 64'(1));
        chk("fwd_rd_q",   64'(q),   64'(32'h0BADCAFE));
        $display("xfer fwd: q=0x%0h", q);
        nxt();

        // Wait-state instance: INCR8 write, reset during the second beat
        b_req = 1'b1; b_adri = 32'h100; b_size = WORD; b_typ = INCR8; b_we = 1'b1; b_d = 32'h12345678;
        @(negedge clk);
        chk("ws_req_ack", 64'(b_req_ack), 64'(1));
        nxt();
        b_req = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            chk($sformatf("ws_ack_t%0d", c), 64'(b_ack), 64'(c == 3 || c == 6));
            if (c == 3) chk("ws_adro_t3", 64'(b_adro), 64'(32'h100));
            if (c == 6) chk("ws_adro_t6", 64'(b_adro), 64'(32'h104));
            $display("xfer ws cycle T+%0d: ack=%0b adro=0x%0h", c, b_ack, b_adro);
            if (c < 6) nxt();
        end
        #1 b_rst_n = 1'b0;
        #1;
        chk("ws_rst_ack",   64'(b_ack),   64'(0));
        chk("ws_rst_d_ack", 64'(b_d_ack), 64'(0));
        chk("ws_rst_err",   64'(b_err),   64'(0));
        chk("ws_rst_adro",  64'(b_adro),  64'(0));
        chk("ws_rst_q",     64'(b_q),     64'(0));
        nxt(); nxt();
        b_rst_n = 1'b1;
        cnt = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (b_ack || b_err) cnt++;
            nxt();
        end
        chk("ws_no_beats_after_rst", 64'(cnt), 64'(0));
        $display("xfer ws reset: beats after release=%0d", cnt);

        b_req = 1'b1; b_adri = 32'h200; b_size = WORD; b_typ = SINGLE; b_we = 1'b0;
        @(negedge clk);
        chk("ws2_req_ack", 64'(b_req_ack), 64'(1));
        nxt();
        b_req = 1'b0;
        for (int c = 1; c <= 3; c++) begin
            @(negedge clk);
            chk($sformatf("ws2_ack_t%0d", c), 64'(b_ack), 64'(c == 3));
            if (c == 3) chk("ws2_adro", 64'(b_adro), 64'(32'h200));
            nxt();
        end
        $display("xfer ws2: single read after reset done");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
